// File: rtl/cdb_rr_sched_if.sv
// Bundle of the per-source result ports and the broadcast (CDB) port of cdb_rr_sched.
// The slave modport is the scheduler's view and the master modport is the view of the pipeline that drives it.
interface cdb_rr_sched_if #(
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int ID_W   = 5
);
  logic                flush;
  logic [3:0]          src_req;
  logic [3:0]          src_rdy;
  logic [4*TAG_W-1:0]  src_tag;
  logic [4*DATA_W-1:0] src_wdata;
  logic [4*ID_W-1:0]   src_inst_id;
  logic                cdb_wr;
  logic [TAG_W-1:0]    cdb_tag;
  logic [DATA_W-1:0]   cdb_wdata;
  logic [ID_W-1:0]     cdb_inst_id;
  logic [1:0]          cdb_src;
  logic                busy;

  modport master (
    output flush, src_req, src_tag, src_wdata, src_inst_id,
    input  src_rdy, cdb_wr, cdb_tag, cdb_wdata, cdb_inst_id, cdb_src, busy
  );

  modport slave (
    input  flush, src_req, src_tag, src_wdata, src_inst_id,
    output src_rdy, cdb_wr, cdb_tag, cdb_wdata, cdb_inst_id, cdb_src, busy
  );
endinterface

// File: rtl/cdb_rr_sched.sv
// Four-source round-robin common-data-bus scheduler: one holding buffer per source,
// one registered broadcast per cycle, and flush / asynchronous reset discard everything buffered.
module cdb_rr_sched #(
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int ID_W   = 5
) (
  input  logic            clk,
  input  logic            rst,
  cdb_rr_sched_if.slave   bus
);
  logic [3:0]        w_valid;
  logic [3:0]        w_grant;
  logic [3:0]        w_rdy;
  logic [3:0]        w_load;
  logic              w_any;
  logic [1:0]        w_gnt_idx;
  logic [1:0]        w_idx;
  logic [TAG_W-1:0]  w_tag_arr   [4];
  logic [DATA_W-1:0] w_wdata_arr [4];
  logic [ID_W-1:0]   w_id_arr    [4];

  logic [1:0]        r_ptr;
  logic              r_cdb_wr;
  logic [TAG_W-1:0]  r_cdb_tag;
  logic [DATA_W-1:0] r_cdb_wdata;
  logic [ID_W-1:0]   r_cdb_inst_id;
  logic [1:0]        r_cdb_src;

  // A buffer that is granted this cycle accepts a new result in the same cycle.
  assign w_rdy = rst ? 4'b1111 : ((~w_valid | w_grant) & {4{~bus.flush}});

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_buf
      logic              r_valid;
      logic [TAG_W-1:0]  r_tag;
      logic [DATA_W-1:0] r_wdata;
      logic [ID_W-1:0]   r_inst_id;

      assign w_load[gi]      = bus.src_req[gi] & w_rdy[gi];
      assign w_valid[gi]     = r_valid;
      assign w_tag_arr[gi]   = r_tag;
      assign w_wdata_arr[gi] = r_wdata;
      assign w_id_arr[gi]    = r_inst_id;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_valid   <= 1'b0;
          r_tag     <= '0;
          r_wdata   <= '0;
          r_inst_id <= '0;
        end else if (bus.flush) begin
          r_valid <= 1'b0;
        end else if (w_load[gi]) begin
          r_valid   <= 1'b1;
          r_tag     <= bus.src_tag[gi*TAG_W +: TAG_W];
          r_wdata   <= bus.src_wdata[gi*DATA_W +: DATA_W];
          r_inst_id <= bus.src_inst_id[gi*ID_W +: ID_W];
        end else if (w_grant[gi]) begin
          r_valid <= 1'b0;
        end
      end
    end
  endgenerate

  // Search upward from r_ptr (mod 4); the first valid buffer found wins.
  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = 2'd0;
    w_idx     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_any && w_valid[w_idx]) begin
        w_any     = 1'b1;
        w_gnt_idx = w_idx;
      end
    end
    if (bus.flush) begin
      w_any = 1'b0;
    end
    w_grant = w_any ? (4'b0001 << w_gnt_idx) : 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr         <= 2'd0;
      r_cdb_wr      <= 1'b0;
      r_cdb_tag     <= '0;
      r_cdb_wdata   <= '0;
      r_cdb_inst_id <= '0;
      r_cdb_src     <= 2'd0;
    end else if (w_any) begin
      r_ptr         <= w_gnt_idx + 2'd1;
      r_cdb_wr      <= 1'b1;
      r_cdb_tag     <= w_tag_arr[w_gnt_idx];
      r_cdb_wdata   <= w_wdata_arr[w_gnt_idx];
      r_cdb_inst_id <= w_id_arr[w_gnt_idx];
      r_cdb_src     <= w_gnt_idx;
    end else begin
      r_cdb_wr <= 1'b0;
    end
  end

  assign bus.src_rdy     = w_rdy;
  assign bus.busy        = |w_valid;
  assign bus.cdb_wr      = r_cdb_wr;
  assign bus.cdb_tag     = r_cdb_tag;
  assign bus.cdb_wdata   = r_cdb_wdata;
  assign bus.cdb_inst_id = r_cdb_inst_id;
  assign bus.cdb_src     = r_cdb_src;
endmodule

// File: tb/tb_cdb_rr_sched.sv
// Self-checking bench for cdb_rr_sched: a behavioural model predicts each cycle's CDB output
// into a scoreboard queue, and a monitor on the falling edge pops from the queue and compares.
module tb_cdb_rr_sched;
  localparam int TW = 6;
  localparam int DW = 32;
  localparam int IW = 5;

  typedef struct {
    bit          wr;
    bit [TW-1:0] tag;
    bit [DW-1:0] data;
    bit [IW-1:0] id;
    bit [1:0]    src;
  } exp_t;

  logic clk;
  logic rst;
  cdb_rr_sched_if #(.TAG_W(TW), .DATA_W(DW), .ID_W(IW)) bus ();

  cdb_rr_sched #(.TAG_W(TW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // values driven by the stimulus
  logic          d_flush;
  logic [3:0]    d_req;
  logic [TW-1:0] d_tag  [4];
  logic [DW-1:0] d_data [4];
  logic [IW-1:0] d_id   [4];

  always_comb begin
    bus.flush       = d_flush;
    bus.src_req     = d_req;
    bus.src_tag     = '0;
    bus.src_wdata   = '0;
    bus.src_inst_id = '0;
    for (int i = 0; i < 4; i++) begin
      bus.src_tag[i*TW +: TW]     = d_tag[i];
      bus.src_wdata[i*DW +: DW]   = d_data[i];
      bus.src_inst_id[i*IW +: IW] = d_id[i];
    end
  end

  // reference model state
  bit          m_valid [4];
  bit [TW-1:0] m_tag   [4];
  bit [DW-1:0] m_data  [4];
  bit [IW-1:0] m_id    [4];
  int          m_ptr;
  exp_t        m_last;
  exp_t        sb [$];

  int n_tests;
  int n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // index of the buffer round-robin would pick right now, -1 if none
  function automatic int model_grant();
    if (d_flush) return -1;
    for (int k = 0; k < 4; k++) begin
      if (m_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_rdy();
    logic [3:0] r;
    int g;
    g = model_grant();
    for (int i = 0; i < 4; i++) begin
      r[i] = (!m_valid[i] || g == i) && !d_flush;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    m_ptr  = 0;
    m_last = '{wr: 1'b0, tag: '0, data: '0, id: '0, src: '0};
  endtask

  // model: step the spec rules once per rising edge and push the expected next output
  always @(posedge clk) begin : model_step
    exp_t e;
    int g;
    logic [3:0] rdy;
    if (rst) begin
      model_reset();
      sb.push_back(m_last);
    end else begin
      g   = model_grant();
      rdy = model_rdy();
      e   = m_last;
      e.wr = 1'b0;
      if (g >= 0) begin
        e = '{wr: 1'b1, tag: m_tag[g], data: m_data[g], id: m_id[g], src: 2'(g)};
        m_valid[g] = 1'b0;
        m_ptr = (g + 1) % 4;
      end
      if (d_flush) begin
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (d_req[i] && rdy[i]) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = d_tag[i];
            m_data[i]  = d_data[i];
            m_id[i]    = d_id[i];
          end
        end
      end
      m_last = e;
      sb.push_back(e);
    end
  end

  // monitor: compare handshake outputs and pop one predicted CDB value per cycle
  always @(negedge clk) begin : monitor
    exp_t e;
    logic [3:0] er;
    bit eb;
    er = rst ? 4'b1111 : model_rdy();
    eb = 1'b0;
    for (int i = 0; i < 4; i++) eb = eb | m_valid[i];
    check("src_rdy", 64'(bus.src_rdy), 64'(er));
    check("busy", 64'(bus.busy), 64'(eb));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("cdb_wr", 64'(bus.cdb_wr), 64'(e.wr));
      check("cdb_payload", {bus.cdb_tag, bus.cdb_wdata, bus.cdb_inst_id, bus.cdb_src},
            {e.tag, e.data, e.id, e.src});
      if (bus.cdb_wr)
        $display("[TB] cdb src=%0d tag=%0d data=%h id=%0d", bus.cdb_src, bus.cdb_tag,
                 bus.cdb_wdata, bus.cdb_inst_id);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    d_req   = 4'b0000;
    d_flush = 1'b0;
    repeat (n) tick();
  endtask

  task automatic set_src(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d,
                         input logic [IW-1:0] id);
    d_tag[i]  = t;
    d_data[i] = d;
    d_id[i]   = id;
  endtask

  task automatic rand_cycle();
    for (int i = 0; i < 4; i++) set_src(i, TW'($urandom), $urandom, IW'($urandom));
    d_req   = 4'($urandom);
    d_flush = ($urandom_range(0, 29) == 0);
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    d_flush = 1'b0;
    d_req   = 4'b0000;
    for (int i = 0; i < 4; i++) set_src(i, '0, '0, '0);
    model_reset();
    repeat (3) tick();
    check("reset_cdb", {bus.cdb_wr, bus.cdb_tag, bus.cdb_wdata, bus.cdb_inst_id, bus.cdb_src}, 64'd0);
    rst = 1'b0;
    tick();

    // single alu result
    set_src(3, 6'd5, 32'hDEADBEEF, 5'd2);
    d_req = 4'b1000;
    tick();
    idle(4);

    // all four at once from ptr 0
    for (int i = 0; i < 4; i++) set_src(i, TW'(10 + i), DW'(32'h100 + i), IW'(i));
    d_req = 4'b1111;
    tick();
    idle(6);

    // sources 0 and 3 continuously
    for (int c = 0; c < 10; c++) begin
      set_src(0, TW'(c), DW'(32'hA000 + c), IW'(c));
      set_src(3, TW'(c + 20), DW'(32'hB000 + c), IW'(c + 16));
      d_req = 4'b1001;
      tick();
    end
    idle(6);

    // back-to-back on source 1
    for (int c = 0; c < 12; c++) begin
      set_src(1, TW'(c + 1), DW'(32'hC000 + c), IW'(c));
      d_req = 4'b0010;
      tick();
    end
    idle(4);

    // flush with buffers 1 and 2 valid
    set_src(1, 6'd7, 32'h1111, 5'd7);
    set_src(2, 6'd8, 32'h2222, 5'd8);
    d_req = 4'b0110;
    tick();
    d_req   = 4'b0110;
    d_flush = 1'b1;
    tick();
    idle(4);

    // random traffic
    repeat (300) rand_cycle();

    // asynchronous reset in the middle of a cycle while traffic is flowing
    for (int i = 0; i < 4; i++) set_src(i, TW'(40 + i), DW'(32'h5000 + i), IW'(20 + i));
    d_req   = 4'b1111;
    d_flush = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    sb.delete();
    model_reset();
    #1;
    check("async_rst_cdb", {bus.cdb_wr, bus.cdb_tag, bus.cdb_wdata, bus.cdb_inst_id, bus.cdb_src}, 64'd0);
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    d_req = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
    idle(5);

    repeat (300) rand_cycle();
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cdb_rr_sched.md
CDB_RR_SCHED -- requirements
Module: cdb_rr_sched

Interface
REQ-001 Parameter TAG_W, default 6, physical register tag width.
REQ-002 Parameter DATA_W, default 32, result data width.
REQ-003 Parameter ID_W, default 5, instruction (ROB) id width.
REQ-004 Number of sources SHALL be fixed at 4, indexed 0=jmp, 1=lsu, 2=mdu, 3=alu.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 flush  input  1  pipeline flush; discards all buffered results.
REQ-008 src_req  input  4  per-source result-valid request.
REQ-009 src_rdy  output  4  per-source acceptance; transfer occurs when src_req[i] and src_rdy[i] are both high.
REQ-010 src_tag  input  4*TAG_W  per-source tags; source i occupies bits [i*TAG_W +: TAG_W].
REQ-011 src_wdata  input  4*DATA_W  per-source result data, packed the same way.
REQ-012 src_inst_id  input  4*ID_W  per-source instruction ids, packed the same way.
REQ-013 cdb_wr  output  1  broadcast valid, registered.
REQ-014 cdb_tag  output  TAG_W  broadcast tag, registered.
REQ-015 cdb_wdata  output  DATA_W  broadcast data, registered.
REQ-016 cdb_inst_id  output  ID_W  broadcast instruction id, registered.
REQ-017 cdb_src  output  2  index of the source whose result is on the CDB, registered.
REQ-018 busy  output  1  high when any holding buffer is valid, combinational from state.

Function
REQ-019 Each source SHALL own a one-entry holding buffer {valid, tag, wdata, inst_id}.
REQ-020 A transfer on source i SHALL load buffer i and set valid[i] at the end of that cycle.
REQ-021 src_rdy[i] SHALL equal (~valid[i] | grant[i]) & ~flush, so a buffer granted this cycle can be refilled in the same cycle.
REQ-022 Each cycle, arbitration SHALL grant at most one valid buffer, using round-robin: search from index ptr upward, modulo 4, and grant the first valid buffer found.
REQ-023 On a grant to index g, ptr SHALL become (g+1) mod 4 at the end of the cycle; with no grant, ptr SHALL hold.
REQ-024 On a grant, the granted buffer's valid bit SHALL clear, unless it is refilled in the same cycle per REQ-021.
REQ-025 On a grant, the next cycle SHALL show cdb_wr=1 with the granted buffer's tag, wdata and inst_id, and cdb_src=g.
REQ-026 Latency from transfer to cdb_wr SHALL be 2 cycles minimum; the CDB SHALL sustain 1 broadcast per cycle.
REQ-027 With no grant, the next cycle SHALL show cdb_wr=0; cdb_tag, cdb_wdata, cdb_inst_id and cdb_src SHALL hold their previous values.
REQ-028 While flush=1: no grant, all valid bits cleared, cdb_wr=0 next cycle, src_rdy=0, ptr held; transfers offered that cycle are dropped.
REQ-029 A buffer SHALL wait at most 3 grants after becoming valid before it is itself granted (starvation bound).
REQ-030 A source whose buffer is full and not granted SHALL see src_rdy=0; its inputs SHALL be ignored.

Reset
REQ-031 rst=1 SHALL asynchronously clear: all valid bits, ptr=0, cdb_wr=0, cdb_tag=0, cdb_wdata=0, cdb_inst_id=0, cdb_src=0.
REQ-032 While rst=1, src_rdy SHALL be 4'b1111 and busy=0; transfers are not captured.
REQ-033 Reset asserted mid-operation SHALL discard all buffered results with no CDB broadcast after deassertion until new transfers arrive.

Verification
REQ-034 Single source: alu (3) req with tag=5, data=0xDEADBEEF, id=2 in cycle 0 -> cdb_wr=1, tag=5, data=0xDEADBEEF, id=2, src=3 in cycle 2; cdb_wr=0 in cycle 3.
REQ-035 All four sources req together in cycle 0 with ptr=0 -> broadcasts in cycles 2,3,4,5 with cdb_src=0,1,2,3; src_rdy=4'b0001 in cycle 1.
REQ-036 Fairness: sources 0 and 3 req continuously with ptr=0 -> cdb_src alternates 0,3,0,3; neither waits more than 1 slot.
REQ-037 Back-to-back: source 1 req every cycle -> src_rdy[1] stays 1 and cdb_wr=1 every cycle from cycle 2, with consecutive inst_ids.
REQ-038 Flush: buffers 1 and 2 valid, flush=1 for one cycle -> cdb_wr=0 next cycle, busy=0, src_rdy=0 during the flush cycle, ptr unchanged.
REQ-039 Async reset mid-stream: rst asserted between edges -> outputs zero immediately, before the next clk edge; after release, no broadcast occurs without a new request.
